// File: rtl/alu_a5_sync_pkg.sv
// Shared constants for the 12-bit registered ALU: data width and opcode encoding.
package alu_a5_sync_pkg;

   localparam int W = 12;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NAND = 4'd5,
      OP_NOR  = 4'd6,
      OP_XNOR = 4'd7,
      OP_NOT  = 4'd8,
      OP_SHL  = 4'd9,
      OP_SHR  = 4'd10,
      OP_SAR  = 4'd11,
      OP_ROL  = 4'd12,
      OP_ROR  = 4'd13,
      OP_INC  = 4'd14,
      OP_DEC  = 4'd15
   } op_e;

endpackage

// File: rtl/alu_a5_sync_comb.sv
// Purely combinational ALU core: opcode decode, result mux and unsigned magnitude compare.
module alu_a5_comb
   import alu_a5_sync_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [3:0]   sel,
   output logic [W-1:0] result,
   output logic         agrtb,
   output logic         altb,
   output logic         aeqb
);

   // Result mux; carries and borrows fall off the top of the 12-bit result.
   always_comb begin
      result = {W{1'b0}};
      case (sel)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NAND: result = ~(a & b);
         OP_NOR:  result = ~(a | b);
         OP_XNOR: result = ~(a ^ b);
         OP_NOT:  result = ~a;
         OP_SHL:  result = {a[W-2:0], 1'b0};
         OP_SHR:  result = {1'b0, a[W-1:1]};
         OP_SAR:  result = {a[W-1], a[W-1:1]};
         OP_ROL:  result = {a[W-2:0], a[W-1]};
         OP_ROR:  result = {a[0], a[W-1:1]};
         OP_INC:  result = a + W'(1);
         OP_DEC:  result = a - W'(1);
         default: result = {W{1'b0}};
      endcase
   end

   // Compare flags are one-hot and independent of the opcode.
   always_comb begin
      agrtb = 1'b0;
      altb  = 1'b0;
      aeqb  = 1'b0;
      if (a > b) begin
         agrtb = 1'b1;
      end else if (a < b) begin
         altb = 1'b1;
      end else begin
         aeqb = 1'b1;
      end
   end

endmodule

// File: rtl/alu_a5_sync.sv
// Single-cycle execute stage: combinational ALU core followed by an output register with synchronous reset.
module alu_a5_sync
   import alu_a5_sync_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [3:0]   sel,
   output logic [W-1:0] result,
   output logic         agrtb,
   output logic         altb,
   output logic         aeqb
);

   logic [W-1:0] result_d, result_q;
   logic         agrtb_d, agrtb_q;
   logic         altb_d, altb_q;
   logic         aeqb_d, aeqb_q;

   alu_a5_comb u_comb (
      .a      (a),
      .b      (b),
      .sel    (sel),
      .result (result_d),
      .agrtb  (agrtb_d),
      .altb   (altb_d),
      .aeqb   (aeqb_d)
   );

   // Output register; reset wins over the operation sampled on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= {W{1'b0}};
         agrtb_q  <= 1'b0;
         altb_q   <= 1'b0;
         aeqb_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         agrtb_q  <= agrtb_d;
         altb_q   <= altb_d;
         aeqb_q   <= aeqb_d;
      end
   end

   assign result = result_q;
   assign agrtb  = agrtb_q;
   assign altb   = altb_q;
   assign aeqb   = aeqb_q;

endmodule

// File: tb/tb_alu_a5_sync.sv
// Scoreboard bench for alu_a5_sync: driver pushes expected responses, monitor pops and compares one cycle later.
module tb_alu_a5_sync;

   logic        clk;
   logic        rst;
   logic [11:0] a;
   logic [11:0] b;
   logic [3:0]  sel;
   logic [11:0] result;
   logic        agrtb;
   logic        altb;
   logic        aeqb;

   typedef struct {
      logic [11:0] res;
      logic [2:0]  flg;   // {agrtb, altb, aeqb}
      string       name;
   } exp_t;

   typedef struct {
      logic [3:0]  sel;
      logic [11:0] a;
      logic [11:0] b;
      logic [11:0] res;
      logic [2:0]  flg;
      string       name;
   } vec_t;

   exp_t exp_q[$];
   int   checks;
   int   errors;
   bit   drive_done;

   alu_a5_sync dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .sel    (sel),
      .result (result),
      .agrtb  (agrtb),
      .altb   (altb),
      .aeqb   (aeqb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model written arithmetically rather than with bit slicing.
   function automatic logic [11:0] model_res(input logic [3:0] s, input logic [11:0] x, input logic [11:0] y);
      int xi, yi, r;
      xi = int'(x);
      yi = int'(y);
      case (s)
         4'd0:    r = xi + yi;
         4'd1:    r = xi - yi;
         4'd2:    r = int'(x & y);
         4'd3:    r = int'(x | y);
         4'd4:    r = int'(x ^ y);
         4'd5:    r = 4095 - int'(x & y);
         4'd6:    r = 4095 - int'(x | y);
         4'd7:    r = 4095 - int'(x ^ y);
         4'd8:    r = 4095 - xi;
         4'd9:    r = xi * 2;
         4'd10:   r = xi / 2;
         4'd11:   r = xi / 2 + ((xi >= 2048) ? 2048 : 0);
         4'd12:   r = xi * 2 + xi / 2048;
         4'd13:   r = xi / 2 + (xi % 2) * 2048;
         4'd14:   r = xi + 1;
         4'd15:   r = xi - 1;
         default: r = 0;
      endcase
      r = ((r % 4096) + 4096) % 4096;
      return r[11:0];
   endfunction

   function automatic logic [2:0] model_flg(input logic [11:0] x, input logic [11:0] y);
      int d;
      d = int'(x) - int'(y);
      return (d > 0) ? 3'b100 : ((d < 0) ? 3'b010 : 3'b001);
   endfunction

   task automatic issue(input logic r, input logic [3:0] s, input logic [11:0] x, input logic [11:0] y,
                        input logic [11:0] er, input logic [2:0] ef, input string nm);
      exp_t e;
      @(negedge clk);
      rst = r;
      sel = s;
      a   = x;
      b   = y;
      e.res  = er;
      e.flg  = ef;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: every cycle with an outstanding expectation, compare just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (result !== e.res) begin
               errors++;
               $display("FAIL %s result: got %03h expected %03h", e.name, result, e.res);
            end
            checks++;
            if ({agrtb, altb, aeqb} !== e.flg) begin
               errors++;
               $display("FAIL %s flags: got %03b expected %03b", e.name, {agrtb, altb, aeqb}, e.flg);
            end
         end
      end
   end

   // Driver: reset, hand-computed directed vectors, then the model-checked sweep.
   initial begin
      vec_t vecs[$];
      logic [11:0] sa, sb;
      int n;
      checks     = 0;
      errors     = 0;
      drive_done = 1'b0;
      rst = 1'b1;
      a   = 12'h3C7;
      b   = 12'h1A2;
      sel = 4'd0;

      issue(1'b1, 4'd3, 12'hABC, 12'h123, 12'h000, 3'b000, "reset0");
      issue(1'b1, 4'd7, 12'h456, 12'h789, 12'h000, 3'b000, "reset1");

      vecs.push_back('{4'd0,  12'hFE1, 12'hFF4, 12'hFD5, 3'b010, "add_wrap"});
      vecs.push_back('{4'd1,  12'hFE7, 12'hFF3, 12'hFF4, 3'b010, "sub_wrap"});
      vecs.push_back('{4'd2,  12'hFEF, 12'hFF4, 12'hFE4, 3'b010, "and"});
      vecs.push_back('{4'd5,  12'h013, 12'h003, 12'hFFC, 3'b100, "nand"});
      vecs.push_back('{4'd8,  12'h049, 12'h000, 12'hFB6, 3'b100, "not"});
      vecs.push_back('{4'd9,  12'h05F, 12'h000, 12'h0BE, 3'b100, "shl"});
      vecs.push_back('{4'd11, 12'h801, 12'h000, 12'hC00, 3'b100, "sar"});
      vecs.push_back('{4'd12, 12'h801, 12'h000, 12'h003, 3'b100, "rol"});
      vecs.push_back('{4'd13, 12'h801, 12'h000, 12'hC00, 3'b100, "ror"});
      vecs.push_back('{4'd14, 12'hFFF, 12'h000, 12'h000, 3'b100, "inc_wrap"});
      vecs.push_back('{4'd15, 12'h000, 12'h000, 12'hFFF, 3'b001, "dec_wrap"});
      vecs.push_back('{4'd4,  12'h5A5, 12'h5A5, 12'h000, 3'b001, "equal"});
      vecs.push_back('{4'd10, 12'h801, 12'hFFF, 12'h400, 3'b010, "shr"});

      foreach (vecs[k]) begin
         issue(1'b0, vecs[k].sel, vecs[k].a, vecs[k].b, vecs[k].res, vecs[k].flg, vecs[k].name);
      end

      for (int i = 0; i < 16; i++) begin
         sa = 12'(i * i + 5 * i - 31);
         sb = 12'(i * i - 2 * i - 12);
         if (i == 8) begin
            issue(1'b1, 4'(i), sa, sb, 12'h000, 3'b000, "sweep_reset");
         end
         issue(1'b0, 4'(i), sa, sb, model_res(4'(i), sa, sb), model_flg(sa, sb), $sformatf("sweep%0d", i));
      end

      @(negedge clk);
      rst = 1'b0;
      drive_done = 1'b1;

      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
